// File: rtl/acc_cpu_pkg.sv
// rtl/acc_cpu_pkg.sv - shared opcode, state and datapath select codes for the accumulator CPU
package acc_cpu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_LOAD  = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_ADDI  = 4'h6;
  localparam logic [3:0] OP_BEQ   = 4'h7;
  localparam logic [3:0] OP_BNE   = 4'h8;
  localparam logic [3:0] OP_J     = 4'h9;
  localparam logic [3:0] OP_JR    = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_ACC    = 2'b10;
  localparam logic [1:0] PCSRC_VECTOR = 2'b11;

  localparam logic [1:0] SRCB_CONST2 = 2'b00;
  localparam logic [1:0] SRCB_MEM    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_AND    = 3'b010;
  localparam logic [2:0] ALU_OR     = 3'b011;
  localparam logic [2:0] ALU_PASS_A = 3'b100;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMRD  = 4'd2,
    ST_WB     = 4'd3,
    ST_MEMWR  = 4'd4,
    ST_EXIMM  = 4'd5,
    ST_BR     = 4'd6,
    ST_JMP    = 4'd7,
    ST_JR     = 4'd8,
    ST_HALT   = 4'd9,
    ST_FAULT  = 4'd10
  } state_e;

  function automatic logic [2:0] alu_op_of(logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - wait-cycle counter that flags a memory access stuck past TIMEOUT_CYCLES
module mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic waiting_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Ready on the last allowed cycle still completes the access.
  assign timeout_o = waiting_i && !ready_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = '0;
    if (waiting_i && !ready_i && !timeout_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle control FSM for the 16-bit accumulator CPU
module multicycle_ctrl
  import acc_cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       Branch,
  output logic       bneOrbeq,
  output logic [1:0] PCSrc,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       ACCWrite,
  output logic       ACCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       halted,
  output logic       fault
);

  state_e state_q, state_d;
  logic   fault_q, fault_d;
  logic   waiting, timeout;

  assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEMRD) || (state_q == ST_MEMWR);
  assign fault   = fault_q;

  mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i    (CLK),
    .rstn_i   (reset),
    .waiting_i(waiting),
    .ready_i  (mem_ready),
    .timeout_o(timeout)
  );

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Outputs stay low whenever reset is held, whatever state the register still holds.
  always_comb begin
    state_d  = state_q;
    fault_d  = fault_q;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    bneOrbeq = 1'b0;
    PCSrc    = PCSRC_ALU;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ACCWrite = 1'b0;
    ACCSrc   = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_CONST2;
    ALUOp    = ALU_ADD;
    halted   = 1'b0;
    if (reset) begin
      case (state_q)
        ST_FETCH: begin
          MemRead = 1'b1;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = ST_DECODE;
          end else if (timeout) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end
        end
        ST_DECODE: begin
          case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LOAD: state_d = ST_MEMRD;
            OP_STORE:       state_d = ST_MEMWR;
            OP_ADDI:        state_d = ST_EXIMM;
            OP_BEQ, OP_BNE: state_d = ST_BR;
            OP_J:           state_d = ST_JMP;
            OP_JR:          state_d = ST_JR;
            OP_HALT:        state_d = ST_HALT;
            default: begin
              state_d = ST_FETCH;
              fault_d = 1'b1;
            end
          endcase
        end
        ST_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (mem_ready) begin
            state_d = ST_WB;
          end else if (timeout) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end
        end
        ST_WB: begin
          ACCWrite = 1'b1;
          if (opcode == OP_LOAD) begin
            ACCSrc = 1'b1;
          end else begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_MEM;
            ALUOp   = alu_op_of(opcode);
          end
          state_d = ST_FETCH;
        end
        ST_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (mem_ready) begin
            state_d = ST_FETCH;
          end else if (timeout) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end
        end
        ST_EXIMM: begin
          ACCWrite = 1'b1;
          ALUSrcA  = 1'b1;
          ALUSrcB  = SRCB_IMM;
          state_d  = ST_FETCH;
        end
        ST_BR: begin
          ALUSrcA  = 1'b1;
          ALUOp    = ALU_PASS_A;
          Branch   = 1'b1;
          PCSrc    = PCSRC_TARGET;
          bneOrbeq = (opcode == OP_BEQ);
          state_d  = ST_FETCH;
        end
        ST_JMP: begin
          PCWrite = 1'b1;
          PCSrc   = PCSRC_TARGET;
          state_d = ST_FETCH;
        end
        ST_JR: begin
          PCWrite = 1'b1;
          PCSrc   = PCSRC_ACC;
          state_d = ST_FETCH;
        end
        ST_HALT: begin
          halted = 1'b1;
        end
        ST_FAULT: begin
          PCWrite = 1'b1;
          PCSrc   = PCSRC_VECTOR;
          state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized trace-model bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam int T = 64;

  logic       CLK = 1'b0;
  logic       reset, mem_ready;
  logic [3:0] opcode;
  logic       PCWrite, Branch, bneOrbeq, IRWrite, IorD, MemRead, MemWrite;
  logic       ACCWrite, ACCSrc, ALUSrcA, halted, fault;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUOp;

  always #5 CLK = ~CLK;

  multicycle_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .Branch(Branch), .bneOrbeq(bneOrbeq), .PCSrc(PCSrc),
    .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .ACCWrite(ACCWrite), .ACCSrc(ACCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .halted(halted), .fault(fault)
  );

  typedef struct packed {
    logic       pcw, br, boe;
    logic [1:0] pcsrc;
    logic       irw, iord, mr, mw, accw, accs, asa;
    logic [1:0] asb;
    logic [2:0] aluop;
    logic       halted, fault;
  } ovec_t;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [3:0] op;
    ovec_t      e;
    logic       chkf;
  } step_t;

  step_t      q[$];
  logic       m_fault = 1'b0;
  logic [3:0] cur_op = 4'h0;
  int         checks = 0, errors = 0, step_no = 0, n_halt = 0;
  ovec_t      dut_o;

  assign dut_o = {PCWrite, Branch, bneOrbeq, PCSrc, IRWrite, IorD, MemRead, MemWrite,
                  ACCWrite, ACCSrc, ALUSrcA, ALUSrcB, ALUOp, halted, fault};

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic ovec_t blank();
    ovec_t v;
    v       = '0;
    v.fault = m_fault;
    return v;
  endfunction

  task automatic push(input logic rdy, input ovec_t e);
    q.push_back('{1'b1, rdy, cur_op, e, 1'b1});
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) q.push_back('{1'b0, rbit(), cur_op, ovec_t'('0), 1'b0});
    m_fault = 1'b0;
  endtask

  // kind 0 = instruction fetch, 1 = data read, 2 = data write; w >= T means memory never answers
  task automatic access(input int kind, input int w, input bit abort, output bit ok);
    ovec_t b, e;
    int    waits;
    b = blank();
    if (kind == 2) b.mw = 1'b1; else b.mr = 1'b1;
    if (kind != 0) b.iord = 1'b1;
    waits = (w >= T) ? T : w;
    for (int i = 0; i < waits; i++) push(1'b0, b);
    ok = 1'b0;
    if (abort) return;
    if (w >= T) begin
      m_fault = 1'b1;
      e       = blank();
      e.pcw   = 1'b1;
      e.pcsrc = 2'b11;
      push(rbit(), e);
      return;
    end
    e = b;
    if (kind == 0) begin
      e.irw = 1'b1;
      e.pcw = 1'b1;
    end
    push(1'b1, e);
    ok = 1'b1;
  endtask

  // For HALT, w2 is the number of halted cycles to observe
  task automatic instr(input logic [3:0] op, input int w1, input int w2);
    bit    ok;
    ovec_t e;
    cur_op = op;
    access(0, w1, 1'b0, ok);
    if (!ok) return;
    push(rbit(), blank());
    e = blank();
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
        access(1, w2, 1'b0, ok);
        if (!ok) return;
        e = blank();
        e.accw = 1'b1;
        if (op == 4'd4) e.accs = 1'b1;
        else begin
          e.asa   = 1'b1;
          e.asb   = 2'b01;
          e.aluop = op[2:0];
        end
        push(rbit(), e);
      end
      4'd5: access(2, w2, 1'b0, ok);
      4'd6: begin
        e.accw = 1'b1; e.asa = 1'b1; e.asb = 2'b10;
        push(rbit(), e);
      end
      4'd7, 4'd8: begin
        e.asa = 1'b1; e.aluop = 3'b100; e.br = 1'b1; e.pcsrc = 2'b01; e.boe = (op == 4'd7);
        push(rbit(), e);
      end
      4'd9, 4'd10: begin
        e.pcw = 1'b1; e.pcsrc = (op == 4'd9) ? 2'b01 : 2'b10;
        push(rbit(), e);
      end
      4'd15: begin
        e.halted = 1'b1;
        for (int i = 0; i < w2; i++) push(rbit(), e);
      end
      default: m_fault = 1'b1;
    endcase
  endtask

  task automatic pin(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run();
    step_t s;
    ovec_t m;
    while (q.size() > 0) begin
      s         = q.pop_front();
      reset     = s.rst;
      mem_ready = s.rdy;
      opcode    = s.op;
      step_no++;
      @(negedge CLK);
      m = s.chkf ? ovec_t'(19'h7FFFF) : ovec_t'(19'h7FFFE);
      checks++;
      if ((dut_o & m) !== (s.e & m)) begin
        errors++;
        $display("FAIL outputs step %0d op %h rst %b rdy %b: got %h expected %h",
                 step_no, s.op, s.rst, s.rdy, dut_o & m, s.e & m);
      end
      checks++;
      if (PCWrite && Branch) begin
        errors++;
        $display("FAIL pcwrite_branch step %0d: got both 1 expected not both", step_no);
      end
      if (halted === 1'b1) n_halt++;
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(99, 0);
    if (r < 85) return $urandom_range(3, 0);
    if (r < 95) return $urandom_range(20, 4);
    return (r < 97) ? T - 1 : T;
  endfunction

  initial begin
    int cnt, r;
    bit ok;
    logic [3:0] op;
    reset     = 1'b0;
    mem_ready = 1'b0;
    opcode    = 4'h0;
    @(posedge CLK);
    #1;
    do_reset(2);
    run();

    instr(4'h0, 0, 0);
    pin("add_len", q.size(), 4);
    pin("add_fetch", int'(q[0].e), 'h42800);
    pin("add_wb", int'(q[3].e), 'h2A0);
    run();

    instr(4'h7, 0, 0);
    pin("beq_br", int'(q[2].e), 'h34090);
    run();
    instr(4'h8, 0, 0);
    pin("bne_br", int'(q[2].e), 'h24090);
    run();

    instr(4'h4, 0, 3);
    cnt = 0;
    foreach (q[i]) if (q[i].e.mr && q[i].e.iord) cnt++;
    pin("load_memread_cycles", cnt, 4);
    pin("load_wb", int'(q[q.size()-1].e), 'h300);
    run();

    instr(4'hC, 0, 0);
    instr(4'h6, 0, 0);
    run();
    pin("illegal_fault", int'(fault), 1);

    cur_op = 4'h4;
    access(0, 0, 1'b0, ok);
    push(rbit(), blank());
    access(1, 2, 1'b1, ok);
    do_reset(2);
    instr(4'h1, 0, 0);
    run();

    instr(4'h0, T, 0);
    instr(4'h2, 1, 1);
    run();
    pin("timeout_fault_sticky", int'(fault), 1);
    do_reset(1);
    instr(4'h0, T - 1, 0);
    instr(4'h5, 0, T - 1);
    instr(4'h3, 0, 0);
    run();
    pin("boundary_no_fault", int'(fault), 0);

    n_halt = 0;
    instr(4'hF, 0, 100);
    run();
    pin("halt_cycles", n_halt, 100);
    do_reset(2);
    run();

    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(99, 0);
      if (r < 4) op = 4'(11 + $urandom_range(3, 0));
      else if (r < 7) op = 4'hF;
      else op = 4'($urandom_range(10, 0));
      instr(op, pick_wait(), (op == 4'hF) ? 3 : pick_wait());
      if (op == 4'hF || $urandom_range(19, 0) == 0) do_reset($urandom_range(2, 1));
      run();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
